// File: rtl/vehicle_pkg.sv
// Encodings shared between the vehicle control FSM and the lamp driver.
// The hazard states exist only when TURN_LAMP_HAZARD_EN is defined.
package vehicle_pkg;

    typedef enum logic [1:0] {
        LOCK    = 2'b00,
        PARKING = 2'b01,
        REVERSE = 2'b10,
        FORWARD = 2'b11
    } gear_t;

    typedef enum logic [1:0] {
        NO_TURN    = 2'b00,
        LEFT_TURN  = 2'b01,
        RIGHT_TURN = 2'b11
    } turn_t;

    typedef enum logic [2:0] {
        IDLE,
        L_ON,
        L_OFF,
        R_ON,
        R_OFF
`ifdef TURN_LAMP_HAZARD_EN
        , H_ON,
        H_OFF
`endif
    } lamp_state_t;

    // A locked car never signals a turn; the unused 2'b10 code reads as no turn.
    function automatic turn_t effective_turn(input logic [1:0] gear, input logic [1:0] turn);
        if (gear == LOCK) return NO_TURN;
        if (turn == 2'b01) return LEFT_TURN;
        if (turn == 2'b11) return RIGHT_TURN;
        return NO_TURN;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Half-period counter for the lamp blink; expire is high on the last cycle
// of a phase and the count wraps to zero on its own after it.
module blink_timer #(
    parameter int HALF_PERIOD = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic expire
);

    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] count;

    assign expire = (count == LAST);

    always_ff @(posedge clock) begin
        if (reset || clear || expire) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/turn_lamp_driver.sv
// Drives indicator, reverse and park lamps plus the relay click and flash count.
// Define TURN_LAMP_HAZARD_EN to add the _hazard input and hazard blink states.
module turn_lamp_driver
    import vehicle_pkg::*;
#(
    parameter int BLINK_HALF_PERIOD = 4,
    parameter int FLASH_CNT_W       = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             _gearState,
    input  logic [1:0]             _turnState,
`ifdef TURN_LAMP_HAZARD_EN
    input  logic                   _hazard,
`endif
    output logic                   _leftLamp,
    output logic                   _rightLamp,
    output logic                   _reverseLamp,
    output logic                   _parkLamp,
    output logic                   _click,
    output logic [FLASH_CNT_W-1:0] _flashCount
);

    function automatic logic [FLASH_CNT_W-1:0] sat_inc(input logic [FLASH_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    lamp_state_t state;
    lamp_state_t nxt;
    turn_t       req;
    logic        hazard;
    logic        cont;
    logic        clear;
    logic        expire;
    logic        enter_on;
    logic        restart;
    logic        left_on;
    logic        right_on;

    blink_timer #(
        .HALF_PERIOD(BLINK_HALF_PERIOD)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .expire(expire)
    );

    assign clear = !cont;

    always_comb begin
        req = effective_turn(_gearState, _turnState);
`ifdef TURN_LAMP_HAZARD_EN
        hazard = _hazard;
`else
        hazard = 1'b0;
`endif
        // cont: the current blink sequence carries on and the timer keeps running
        case (state)
            L_ON, L_OFF: cont = !hazard && (req == LEFT_TURN);
            R_ON, R_OFF: cont = !hazard && (req == RIGHT_TURN);
`ifdef TURN_LAMP_HAZARD_EN
            H_ON, H_OFF: cont = hazard;
`endif
            default:     cont = 1'b0;
        endcase

        nxt      = state;
        enter_on = 1'b0;
        restart  = 1'b0;
        if (!cont) begin
            restart  = 1'b1;
            enter_on = 1'b1;
`ifdef TURN_LAMP_HAZARD_EN
            if (hazard) begin
                nxt = H_ON;
            end else
`endif
            if (req == LEFT_TURN) begin
                nxt = L_ON;
            end else if (req == RIGHT_TURN) begin
                nxt = R_ON;
            end else begin
                nxt      = IDLE;
                restart  = 1'b0;
                enter_on = 1'b0;
            end
        end else if (expire) begin
            case (state)
                L_ON:    nxt = L_OFF;
                L_OFF:   begin nxt = L_ON; enter_on = 1'b1; end
                R_ON:    nxt = R_OFF;
                R_OFF:   begin nxt = R_ON; enter_on = 1'b1; end
`ifdef TURN_LAMP_HAZARD_EN
                H_ON:    nxt = H_OFF;
                H_OFF:   begin nxt = H_ON; enter_on = 1'b1; end
`endif
                default: nxt = state;
            endcase
        end

`ifdef TURN_LAMP_HAZARD_EN
        left_on  = (nxt == L_ON) || (nxt == H_ON);
        right_on = (nxt == R_ON) || (nxt == H_ON);
`else
        left_on  = (nxt == L_ON);
        right_on = (nxt == R_ON);
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            _leftLamp    <= 1'b0;
            _rightLamp   <= 1'b0;
            _reverseLamp <= 1'b0;
            _parkLamp    <= 1'b0;
            _click       <= 1'b0;
            _flashCount  <= '0;
        end else begin
            state        <= nxt;
            _leftLamp    <= left_on;
            _rightLamp   <= right_on;
            _reverseLamp <= (_gearState == REVERSE);
            _parkLamp    <= (_gearState == PARKING);
            _click       <= enter_on;
            if (nxt == IDLE) begin
                _flashCount <= '0;
            end else if (restart) begin
                _flashCount <= FLASH_CNT_W'(1);
            end else if (enter_on) begin
                _flashCount <= sat_inc(_flashCount);
            end
        end
    end

endmodule

// File: tb/tb_turn_lamp_driver.sv
// Table-driven scoreboard bench for turn_lamp_driver (half period 4), with
// side instances for a 2-bit flash counter and a half period of 1.
module tb_turn_lamp_driver;

    logic       clock;
    logic       reset;
    logic [1:0] gear;
    logic [1:0] turn;

    logic       left, right, rev, park, click;
    logic [7:0] flash;
    logic       s_left, s_right, s_rev, s_park, s_click;
    logic [1:0] s_flash;
    logic       h_left, h_right, h_rev, h_park, h_click;
    logic [7:0] h_flash;

    turn_lamp_driver #(.BLINK_HALF_PERIOD(4), .FLASH_CNT_W(8)) dut (
        .clock(clock), .reset(reset), ._gearState(gear), ._turnState(turn),
`ifdef TURN_LAMP_HAZARD_EN
        ._hazard(1'b0),
`endif
        ._leftLamp(left), ._rightLamp(right), ._reverseLamp(rev),
        ._parkLamp(park), ._click(click), ._flashCount(flash)
    );

    turn_lamp_driver #(.BLINK_HALF_PERIOD(4), .FLASH_CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), ._gearState(gear), ._turnState(turn),
`ifdef TURN_LAMP_HAZARD_EN
        ._hazard(1'b0),
`endif
        ._leftLamp(s_left), ._rightLamp(s_right), ._reverseLamp(s_rev),
        ._parkLamp(s_park), ._click(s_click), ._flashCount(s_flash)
    );

    turn_lamp_driver #(.BLINK_HALF_PERIOD(1), .FLASH_CNT_W(8)) dut_hp1 (
        .clock(clock), .reset(reset), ._gearState(gear), ._turnState(turn),
`ifdef TURN_LAMP_HAZARD_EN
        ._hazard(1'b0),
`endif
        ._leftLamp(h_left), ._rightLamp(h_right), ._reverseLamp(h_rev),
        ._parkLamp(h_park), ._click(h_click), ._flashCount(h_flash)
    );

    typedef struct {
        logic       rst;
        logic [1:0] gear;
        logic [1:0] turn;
        logic       left, right, rev, park, click;
        logic [7:0] flash;
        logic       aux;
        logic [1:0] sat_flash;
        logic       sat_click;
        logic       h1_left;
        logic       h1_click;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic add(input logic r, input logic [1:0] g, input logic [1:0] t,
                       input logic l, input logic rt, input logic rv, input logic p,
                       input logic c, input int f);
        vec_t v;
        v.rst = r; v.gear = g; v.turn = t;
        v.left = l; v.right = rt; v.rev = rv; v.park = p; v.click = c;
        v.flash = 8'(f);
        v.aux = 1'b0; v.sat_flash = 2'd0; v.sat_click = 1'b0;
        v.h1_left = 1'b0; v.h1_click = 1'b0;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int step, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        vec_t v;
        reset = 1'b1; gear = 2'b11; turn = 2'b00;

        // reset held with a left request pending
        add(1, 2'b11, 2'b01, 0, 0, 0, 0, 0, 0);
        add(1, 2'b11, 2'b01, 0, 0, 0, 0, 0, 0);
        // left held: 4 on, 4 off, clicks every 8 cycles; ends in the off phase
        for (int k = 1; k <= 21; k++)
            add(0, 2'b11, 2'b01, ((k-1)/4) % 2 == 0, 0, 0, 0, (k-1) % 8 == 0, (k-1)/8 + 1);
        // reversal mid off-phase: right lights at once with a fresh count
        add(0, 2'b11, 2'b11, 0, 1, 0, 0, 1, 1);
        for (int k = 0; k < 3; k++)
            add(0, 2'b11, 2'b11, 0, 1, 0, 0, 0, 1);
        // lock cancels, illegal turn code is ignored
        add(0, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0);
        add(0, 2'b11, 2'b10, 0, 0, 0, 0, 0, 0);
        add(0, 2'b11, 2'b10, 0, 0, 0, 0, 0, 0);
        // gear lamps, one cycle each
        add(0, 2'b01, 2'b00, 0, 0, 0, 1, 0, 0);
        add(0, 2'b10, 2'b00, 0, 0, 1, 0, 0, 0);
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        add(0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        // turning in reverse, then reset mid-blink, then restart
        add(0, 2'b10, 2'b01, 1, 0, 1, 0, 1, 1);
        add(1, 2'b11, 2'b01, 0, 0, 0, 0, 0, 0);
        add(0, 2'b11, 2'b01, 1, 0, 0, 0, 1, 1);
        add(0, 2'b11, 2'b01, 1, 0, 0, 0, 0, 1);
        // long left run: saturation of the 2-bit counter and half period 1
        add(1, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        vecs[vecs.size()-1].aux = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            add(0, 2'b11, 2'b01, ((k-1)/4) % 2 == 0, 0, 0, 0, (k-1) % 8 == 0, (k-1)/8 + 1);
            vecs[vecs.size()-1].aux       = 1'b1;
            vecs[vecs.size()-1].sat_flash = ((k-1)/8 + 1 > 3) ? 2'd3 : 2'((k-1)/8 + 1);
            vecs[vecs.size()-1].sat_click = ((k-1) % 8 == 0);
            vecs[vecs.size()-1].h1_left   = (k % 2 == 1);
            vecs[vecs.size()-1].h1_click  = (k % 2 == 1);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clock);
            reset = v.rst; gear = v.gear; turn = v.turn;
            sb.push_back(v);
            @(posedge clock);
            #1;
            if (sb.size() == 0) begin
                check("scoreboard_empty", i, 1, 0);
            end else begin
                e = sb.pop_front();
                check("left",  i, int'(left),  int'(e.left));
                check("right", i, int'(right), int'(e.right));
                check("rev",   i, int'(rev),   int'(e.rev));
                check("park",  i, int'(park),  int'(e.park));
                check("click", i, int'(click), int'(e.click));
                check("flash", i, int'(flash), int'(e.flash));
                if (e.aux) begin
                    check("sat_flash", i, int'(s_flash), int'(e.sat_flash));
                    check("sat_click", i, int'(s_click), int'(e.sat_click));
                    check("hp1_left",  i, int'(h_left),  int'(e.h1_left));
                    check("hp1_click", i, int'(h_click), int'(e.h1_click));
                    check("hp1_right", i, int'(h_right), 0);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/turn_lamp_driver.md
Name: turn_lamp_driver

Overview:
- Downstream stage of the vehicle control FSM.
- Consumes the registered gear and turn states and drives the physical lamps: blinking left/right indicators, reverse lamp and park lamp.
- Also drives a one-cycle click pulse for the audible indicator relay and a per-signal flash counter for the dashboard.
- Synchronous, single clock domain.

Parameters:
- BLINK_HALF_PERIOD, 4, clock cycles per lamp on-phase and per off-phase; legal range 1..65535.
- FLASH_CNT_W, 8, width of the saturating flash counter.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- _gearState  input  2  gear state: 00 LOCK, 01 PARKING, 10 REVERSE, 11 FORWARD.
- _turnState  input  2  turn state: 00 NO_TURN, 01 LEFT_TURN, 11 RIGHT_TURN; 10 is illegal and treated as NO_TURN.
- _leftLamp  output  1  left indicator lamp drive.
- _rightLamp  output  1  right indicator lamp drive.
- _reverseLamp  output  1  high while gear is REVERSE.
- _parkLamp  output  1  high while gear is PARKING.
- _click  output  1  one-cycle pulse on every lamp off-to-on transition.
- _flashCount  output  FLASH_CNT_W  on-phases since the current signal started.

Behaviour:
- Reset:
  - Single clock and reset; reset is synchronous and active-high.
  - All outputs are 0 in the cycle after reset is sampled high.
  - FSM goes to IDLE and the half-period counter to 0.
  - Reset mid-blink aborts immediately with no click.
- All outputs are registered.
  - Latency from an input change to its output effect is 1 cycle.
- _reverseLamp <= (_gearState==REVERSE); _parkLamp <= (_gearState==PARKING).
- FSM states: IDLE, L_ON, L_OFF, R_ON, R_OFF.
- Effective turn request:
  - NO_TURN if _gearState==LOCK or _turnState is 00 or 10.
  - Otherwise LEFT or RIGHT.
- Transitions, evaluated every cycle, in priority order:
  - Request NO_TURN: from any state go to IDLE, counter=0, _flashCount=0, lamps off next cycle.
  - Request LEFT while in IDLE, R_ON or R_OFF: go to L_ON, counter=0, _click=1, _flashCount=1 (restart, not increment).
  - RIGHT from IDLE, L_ON or L_OFF: symmetric, going to R_ON.
  - Same direction, counter==BLINK_HALF_PERIOD-1: toggle ON<->OFF and set counter=0.
    - Entering ON raises _click for one cycle and increments _flashCount.
  - Same direction otherwise: counter+1.
- Lamp outputs: _leftLamp=1 only in L_ON; _rightLamp=1 only in R_ON.
  - The lamp lights the cycle after the request is first sampled.
- BLINK_HALF_PERIOD=1: lamp toggles every cycle and a click occurs every 2 cycles.
- _flashCount saturates at 2^FLASH_CNT_W-1 and never wraps.
- Counter width is $clog2(BLINK_HALF_PERIOD), minimum 1 bit. The counter never exceeds BLINK_HALF_PERIOD-1.
- Direction reversal mid-phase restarts the blink phase immediately; there is no off gap.

Optional Feature:
- Macro: TURN_LAMP_HAZARD_EN.
- Defined:
  - Adds input _hazard (1 bit) and states H_ON and H_OFF.
  - _hazard=1 has priority over every turn request and over LOCK, so hazards work with the car off.
  - From any non-hazard state, _hazard=1 goes to H_ON with counter=0, _click=1 and _flashCount=1.
  - In H_ON both lamps are on; they blink in phase with the same timing rules as turn signals.
  - Deassert _hazard: re-evaluate the turn request as if from IDLE.
- Undefined: no _hazard port and no hazard states; behaviour is exactly as above.

Decomposition:
- Shared package vehicle_pkg:
  - gear_t enum (LOCK, PARKING, REVERSE, FORWARD).
  - turn_t enum (NO_TURN, LEFT_TURN, RIGHT_TURN).
  - lamp_state_t enum for this FSM.
  - The encodings are shared with the vehicle control block.
- Sub-module blink_timer:
  - Parameterised half-period counter with sync clear.
  - Outputs a one-cycle "expire" pulse when count==BLINK_HALF_PERIOD-1.
  - The FSM consumes expire and drives clear.

Test Plan (BLINK_HALF_PERIOD=4):
- Reset held 2 cycles with gear=FORWARD, turn=LEFT -> all outputs 0; after release, _leftLamp=1 and _click=1 next cycle.
- Gear FORWARD, turn=LEFT held 16 cycles:
  - _leftLamp pattern is 1111 0000 1111 0000.
  - _click pulses at cycles 1 and 9.
  - _flashCount reads 1 then 2.
  - _rightLamp=0 throughout.
- Turn LEFT in L_OFF, then switch to RIGHT -> next cycle _rightLamp=1, _leftLamp=0, _click=1, _flashCount=1.
- Turn RIGHT blinking, gear forced to LOCK -> next cycle both lamps 0, _flashCount=0, no click; turn=10 with gear FORWARD -> lamps stay 0.
- Gear sequence PARKING, REVERSE, FORWARD, one cycle each:
  - _parkLamp=1 only in cycle 1.
  - _reverseLamp=1 only in cycle 2.
  - Each lags its input by 1 cycle.
- FLASH_CNT_W=2, turn LEFT held 40 cycles -> _flashCount saturates at 3; _click still pulses every 8 cycles.
